// File: rtl/i2c_slave_read_resp.sv
// I2C slave that answers master reads with a 16-bit payload, wrapping byte 0/1 until NACK.
// Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample majority filter on synchronized SCL/SDA.
module i2c_slave_read_resp #(
    parameter int unsigned SDA_HOLD = 2
) (
    input  logic        PT_CK,
    input  logic        RESET_N,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic        SCLI,
    input  logic        SDAI,
    input  logic [15:0] DATA16,
    output logic        SDAO,
    output logic        BUSY,
    output logic        RD_DONE,
    output logic [2:0]  ST
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        TX       = 3'd3,
        MACK     = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(SDA_HOLD - 1);

    logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic        scl_v, sda_v;
    logic        scl_p_q, sda_p_q;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  hold_q, hold_d;
    logic        tick;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  addr_sr_q, addr_sr_d;
    logic [15:0] data_sr_q, data_sr_d;
    logic        sdao_q, sdao_d;
    logic        busy_q, busy_d;
    logic        matched_q, matched_d;
    logic        acked_q, acked_d;
    logic        byte_q, byte_d;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = SLAVE_ADDRESS[0];

    always_comb begin
        scl_sync_d = {scl_sync_q[0], SCLI};
        sda_sync_d = {sda_sync_q[0], SDAI};
    end

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
    end

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    // Two of three samples must agree, so a lone one-cycle pulse never wins.
    assign scl_v = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                   (scl_hist_q[1] & scl_hist_q[2]);
    assign sda_v = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                   (sda_hist_q[1] & sda_hist_q[2]);
`else
    assign scl_v = scl_sync_q[1];
    assign sda_v = sda_sync_q[1];
`endif

    assign scl_rise  = scl_v & ~scl_p_q;
    assign scl_fall  = ~scl_v & scl_p_q;
    assign start_det = scl_v & scl_p_q & sda_p_q & ~sda_v;
    assign stop_det  = scl_v & scl_p_q & ~sda_p_q & sda_v;

    // tick marks the cycle whose edge updates SDAO, SDA_HOLD cycles after the SCL fall.
    always_comb begin
        hold_d = hold_q;
        tick   = 1'b0;
        if (scl_fall) begin
            hold_d = HOLD_M1;
            tick   = (SDA_HOLD == 1);
        end else if (scl_rise) begin
            hold_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 4'd1;
            tick   = (hold_q == 4'd1) && !scl_v;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_sr_d = addr_sr_q;
        data_sr_d = data_sr_q;
        sdao_d    = sdao_q;
        busy_d    = busy_q;
        matched_d = matched_q;
        acked_d   = acked_q;
        byte_d    = byte_q;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sdao_d    = 1'b1;
            busy_d    = 1'b0;
            matched_d = 1'b0;
            acked_d   = 1'b0;
        end else if (stop_det && state_q != DONE) begin
            state_d   = IDLE;
            sdao_d    = 1'b1;
            busy_d    = 1'b0;
            matched_d = 1'b0;
            acked_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise && !matched_q) begin
                        addr_sr_d = {addr_sr_q[5:0], sda_v};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (addr_sr_q == SLAVE_ADDRESS[7:1] && sda_v) matched_d = 1'b1;
                            else state_d = IDLE;
                        end
                    end else if (tick && matched_q) begin
                        sdao_d    = 1'b0;
                        data_sr_d = DATA16;
                        busy_d    = 1'b1;
                        byte_d    = 1'b0;
                        matched_d = 1'b0;
                        state_d   = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (tick) begin
                        sdao_d    = data_sr_q[15];
                        data_sr_d = {data_sr_q[14:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        state_d   = TX;
                    end
                end
                TX: begin
                    if (tick) begin
                        if (bit_cnt_q == 4'd8) begin
                            sdao_d  = 1'b1;
                            acked_d = 1'b0;
                            state_d = MACK;
                        end else begin
                            sdao_d    = data_sr_q[15];
                            data_sr_d = {data_sr_q[14:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                MACK: begin
                    if (scl_rise && !acked_q) begin
                        if (sda_v) state_d = DONE;
                        else acked_d = 1'b1;
                    end else if (tick && acked_q) begin
                        acked_d   = 1'b0;
                        bit_cnt_d = 4'd1;
                        state_d   = TX;
                        // byte_q is the byte just acknowledged; after byte 1 the payload is re-sampled.
                        if (byte_q) begin
                            sdao_d    = DATA16[15];
                            data_sr_d = {DATA16[14:0], 1'b0};
                            byte_d    = 1'b0;
                        end else begin
                            sdao_d    = data_sr_q[15];
                            data_sr_d = {data_sr_q[14:0], 1'b0};
                            byte_d    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    sdao_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    sdao_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            hold_q    <= '0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            addr_sr_q <= '0;
            data_sr_q <= '0;
            sdao_q    <= 1'b1;
            busy_q    <= 1'b0;
            matched_q <= 1'b0;
            acked_q   <= 1'b0;
            byte_q    <= 1'b0;
        end else begin
            scl_p_q   <= scl_v;
            sda_p_q   <= sda_v;
            hold_q    <= hold_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_sr_q <= addr_sr_d;
            data_sr_q <= data_sr_d;
            sdao_q    <= sdao_d;
            busy_q    <= busy_d;
            matched_q <= matched_d;
            acked_q   <= acked_d;
            byte_q    <= byte_d;
        end
    end

    assign SDAO    = sdao_q;
    assign BUSY    = busy_q;
    assign RD_DONE = (state_q == DONE);
    assign ST      = 3'(state_q);

endmodule

// File: tb/tb_i2c_slave_read_resp.sv
// Scoreboard bench for i2c_slave_read_resp: a bit-banged master drives the bus, a monitor checks SDAO frames.
// Covers the glitch-filter case only when I2C_SLV_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_read_resp;
    typedef enum int {K_SDAO, K_BUSY, K_RDDONE, K_ST, K_MARK, K_RDCNT, K_BUSYCNT, K_QEMPTY} kind_e;
    typedef struct {
        kind_e kind;
        int    exp;
        string name;
    } req_t;

`ifdef I2C_SLV_GLITCH_FILTER_EN
    localparam int STOP_LAT = 4;
`else
    localparam int STOP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        force_drv = 1'b0;
    logic        glitch = 1'b0;
    logic [15:0] data16 = 16'hA55A;
    logic        sda_bus;
    logic        sdao, busy, rd_done;
    logic [2:0]  st;

    req_t        req_q[$];
    logic [8:0]  exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    // Open-drain bus; force_drv lets the master overdrive a slave holding SDA low.
    assign sda_bus = force_drv ? sda_m : (sda_m & sdao);

    i2c_slave_read_resp #(.SDA_HOLD(2)) dut (
        .PT_CK        (clk),
        .RESET_N      (rst_n),
        .SLAVE_ADDRESS(8'h6C),
        .SCLI         (scl),
        .SDAI         (sda_bus),
        .DATA16       (data16),
        .SDAO         (sdao),
        .BUSY         (busy),
        .RD_DONE      (rd_done),
        .ST           (st)
    );

    // Monitor: tracks bus frames itself and compares SDAO over each 9-clock frame.
    logic       m_scl_p = 1'b1;
    logic       m_sda_p = 1'b1;
    logic       in_frame = 1'b0;
    int         nbits = 0;
    logic [8:0] frame = '0;
    int         rd_cnt = 0;
    int         busy_cnt = 0;

    always begin
        req_t       r;
        int         act;
        logic [8:0] e;
        @(posedge clk or negedge rst_n);
        #1;
        if (clk) begin
            if (!rst_n) begin
                in_frame = 1'b0;
                nbits    = 0;
            end else if (scl && m_scl_p && m_sda_p && !sda_bus) begin
                in_frame = 1'b1;
                nbits    = 0;
            end else if (scl && m_scl_p && !m_sda_p && sda_bus) begin
                in_frame = 1'b0;
                nbits    = 0;
            end else if (scl && !m_scl_p && in_frame && !glitch) begin
                frame = {frame[7:0], sdao};
                nbits++;
                if (nbits == 9) begin
                    nbits = 0;
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL frame: got SDAO pattern %h, required none (no expectation queued)", frame);
                    end else begin
                        e = exp_q.pop_front();
                        if (frame === e) n_pass++;
                        else $display("FAIL frame: got SDAO pattern %h, required %h", frame, e);
                    end
                end
            end
            if (rd_done) rd_cnt++;
            if (busy) busy_cnt++;
            m_scl_p = scl;
            m_sda_p = sda_bus;
        end
        while (req_q.size() > 0) begin
            r = req_q.pop_front();
            act = -1;
            case (r.kind)
                K_MARK: begin
                    rd_cnt   = 0;
                    busy_cnt = 0;
                end
                K_SDAO:    act = int'(sdao);
                K_BUSY:    act = int'(busy);
                K_RDDONE:  act = int'(rd_done);
                K_ST:      act = int'(st);
                K_RDCNT:   act = rd_cnt;
                K_BUSYCNT: act = busy_cnt;
                K_QEMPTY:  act = exp_q.size();
                default:   act = -1;
            endcase
            if (r.kind != K_MARK) begin
                n_total++;
                if (act == r.exp) n_pass++;
                else $display("FAIL %s: got %0d, required %0d", r.name, act, r.exp);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input kind_e k, input int e, input string name);
        req_q.push_back('{kind: k, exp: e, name: name});
        wait_clk(1);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(5);
        sda_m = b;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        scl = 1'b0;
    endtask

    task automatic send_bit_glitch(input logic b);
        wait_clk(5);
        sda_m = b;
        wait_clk(2);
        glitch = 1'b1;
        scl = 1'b1;
        wait_clk(1);
        scl = 1'b0;
        wait_clk(2);
        glitch = 1'b0;
        scl = 1'b1;
        wait_clk(10);
        scl = 1'b0;
    endtask

    task automatic addr_frame(input logic [7:0] a);
        logic [7:0] v;
        v = a;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(1'b1);
    endtask

    task automatic read_frame(input logic nack);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(nack);
    endtask

    initial begin
        rst_n = 1'b0;
        wait_clk(2);
        chk(K_SDAO, 1, "reset_sdao");
        chk(K_BUSY, 0, "reset_busy");
        chk(K_RDDONE, 0, "reset_rd_done");
        chk(K_ST, 0, "reset_st");
        rst_n = 1'b1;
        wait_clk(5);

        // Read 0x6D, two bytes, NACK on the second.
        chk(K_MARK, 0, "mark");
        exp_q.push_back(9'h1FE);
        exp_q.push_back({8'hA5, 1'b1});
        exp_q.push_back({8'h5A, 1'b1});
        bus_start();
        addr_frame(8'h6D);
        chk(K_BUSY, 1, "read_busy_after_ack");
        read_frame(1'b0);
        read_frame(1'b1);
        bus_stop();
        chk(K_RDCNT, 1, "read_rd_done_pulses");
        chk(K_BUSY, 0, "read_busy_after");
        chk(K_ST, 0, "read_st_after");

        // Write address: NACK, back to idle, never busy.
        chk(K_MARK, 0, "mark");
        exp_q.push_back(9'h1FF);
        bus_start();
        addr_frame(8'h6C);
        chk(K_ST, 0, "write_st_idle");
        bus_stop();
        chk(K_BUSYCNT, 0, "write_busy_cycles");
        chk(K_RDCNT, 0, "write_rd_done_pulses");

        // Three ACKed bytes wrap to byte 0, fourth NACKed.
        data16 = 16'h1234;
        chk(K_MARK, 0, "mark");
        exp_q.push_back(9'h1FE);
        exp_q.push_back({8'h12, 1'b1});
        exp_q.push_back({8'h34, 1'b1});
        exp_q.push_back({8'h12, 1'b1});
        exp_q.push_back({8'h34, 1'b1});
        bus_start();
        addr_frame(8'h6D);
        read_frame(1'b0);
        read_frame(1'b0);
        read_frame(1'b0);
        read_frame(1'b1);
        bus_stop();
        chk(K_RDCNT, 1, "wrap_rd_done_pulses");

        // Payload change mid-flight only shows up at the wrap reload.
        data16 = 16'hC33C;
        exp_q.push_back(9'h1FE);
        exp_q.push_back({8'hC3, 1'b1});
        exp_q.push_back({8'h3C, 1'b1});
        exp_q.push_back({8'h0F, 1'b1});
        bus_start();
        addr_frame(8'h6D);
        data16 = 16'h0FF0;
        read_frame(1'b0);
        read_frame(1'b0);
        read_frame(1'b1);
        bus_stop();

        // STOP after four bits of byte 0 while the slave drives 0.
        data16 = 16'hA55A;
        chk(K_MARK, 0, "mark");
        exp_q.push_back(9'h1FE);
        bus_start();
        addr_frame(8'h6D);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        force_drv = 1'b1;
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(3);
        chk(K_SDAO, 0, "stop_sdao_before");
        wait_clk(3);
        sda_m = 1'b1;
        wait_clk(STOP_LAT);
        chk(K_SDAO, 1, "stop_sdao_released");
        chk(K_ST, 0, "stop_st");
        chk(K_BUSY, 0, "stop_busy");
        chk(K_RDCNT, 0, "stop_rd_done_pulses");
        force_drv = 1'b0;
        wait_clk(10);

        // Reset while the slave pulls SDA low, then a fresh read.
        chk(K_MARK, 0, "mark");
        exp_q.push_back(9'h1FE);
        bus_start();
        addr_frame(8'h6D);
        send_bit(1'b1);
        wait_clk(5);
        wait_clk(5);
        scl = 1'b1;
        wait_clk(3);
        chk(K_SDAO, 0, "rst_sdao_before");
        #2;
        req_q.push_back('{kind: K_SDAO, exp: 1, name: "rst_sdao_async"});
        rst_n = 1'b0;
        wait_clk(1);
        chk(K_ST, 0, "rst_st");
        chk(K_BUSY, 0, "rst_busy");
        rst_n = 1'b1;
        wait_clk(5);
        exp_q.push_back(9'h1FE);
        exp_q.push_back({8'hA5, 1'b1});
        bus_start();
        addr_frame(8'h6D);
        read_frame(1'b1);
        bus_stop();
        chk(K_RDCNT, 1, "rst_rd_done_pulses");

`ifdef I2C_SLV_GLITCH_FILTER_EN
        // One-cycle SCL pulse inside an address bit must not be shifted in.
        chk(K_MARK, 0, "mark");
        exp_q.push_back(9'h1FE);
        exp_q.push_back({8'hA5, 1'b1});
        bus_start();
        begin
            logic [7:0] a;
            a = 8'h6D;
            for (int i = 7; i >= 0; i--) begin
                if (i == 4) send_bit_glitch(a[i]);
                else send_bit(a[i]);
            end
        end
        send_bit(1'b1);
        read_frame(1'b1);
        bus_stop();
        chk(K_RDCNT, 1, "glitch_rd_done_pulses");
`endif

        chk(K_QEMPTY, 0, "frames_outstanding");
        wait_clk(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
